// File: rtl/tqvp_matt_encoder_event_arb.sv
// tqvp_matt_encoder_event_arb
//   Round-robin event scheduler for four quadrature encoder counters. Each
//   cycle one changed channel is picked, its signed movement (saturated to
//   6 bits) is pushed into a small FIFO as {channel, delta}, and the core
//   drains the FIFO over the peripheral bus. A level IRQ is raised while
//   events are waiting.
//
// Ports
//   clk          peripheral clock
//   rst_n        asynchronous active-low reset
//   i_enc_value  four packed channel counts, ch i at [i*WIDTH +: WIDTH]
//   i_address    register address
//   i_data_write one-cycle write strobe
//   i_data_in    write data
//   o_data_out   combinational read data
//   o_irq        high while enabled and the FIFO holds entries
module tqvp_matt_encoder_event_arb #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4*WIDTH-1:0] i_enc_value,
  input  logic [3:0]         i_address,
  input  logic               i_data_write,
  input  logic [7:0]         i_data_in,
  output logic [7:0]         o_data_out,
  output logic               o_irq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic signed [WIDTH-1:0] MaxDelta = WIDTH'(31);
  localparam logic signed [WIDTH-1:0] MinDelta = -WIDTH'(32);

  logic [7:0]       r_mem [DEPTH];
  logic [PW-1:0]    r_rdPtr;
  logic [PW-1:0]    r_wrPtr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_last [4];
  logic [1:0]       r_rrPtr;
  logic             r_enable;

  logic [WIDTH-1:0]        w_enc [4];
  logic [3:0]              w_pend;
  logic                    w_found;
  logic [1:0]              w_gnt;
  logic [1:0]              w_idx;
  logic signed [WIDTH-1:0] w_diff;
  logic signed [WIDTH-1:0] w_sat;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_flush;
  logic                    w_push;
  logic                    w_ctrlWrite;

  // Unpack the channel counts and flag every channel whose count moved
  // since it was last reported.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_enc[i]  = i_enc_value[i*WIDTH +: WIDTH];
      w_pend[i] = (w_enc[i] != r_last[i]);
    end
  end

  // First pending channel starting at the round-robin pointer wins.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = 2'd0;
    w_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_rrPtr + 2'(k);
      if (!w_found && w_pend[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end

  // Movement is read as a signed modular difference and clamped to the
  // 6-bit field; whatever is clipped off stays pending for later grants.
  always_comb begin
    w_diff = w_enc[w_gnt] - r_last[w_gnt];
    if (w_diff > MaxDelta) begin
      w_sat = MaxDelta;
    end else if (w_diff < MinDelta) begin
      w_sat = MinDelta;
    end else begin
      w_sat = w_diff;
    end
  end

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_ctrlWrite = i_data_write && (i_address == 4'hB);
  assign w_flush     = w_ctrlWrite && i_data_in[1];
  // Fullness is judged before any pop so a same-cycle pop never frees a slot
  // for a push; flush suppresses both pop and push.
  assign w_pop       = i_data_write && (i_address == 4'h9) && !w_empty && !w_flush;
  assign w_push      = r_enable && !w_full && !w_flush && w_found;

  // FIFO, per-channel reported position and arbitration state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
      for (int i = 0; i < 4; i++) r_last[i] <= '0;
      r_rdPtr  <= '0;
      r_wrPtr  <= '0;
      r_count  <= '0;
      r_rrPtr  <= 2'd0;
      r_enable <= 1'b1;
    end else begin
      if (w_ctrlWrite) begin
        r_enable <= i_data_in[0];
      end
      if (w_flush) begin
        r_rdPtr <= '0;
        r_wrPtr <= '0;
        r_count <= '0;
        r_rrPtr <= 2'd0;
        for (int i = 0; i < 4; i++) r_last[i] <= w_enc[i];
      end else begin
        if (w_pop) begin
          r_rdPtr <= r_rdPtr + PW'(1);
        end
        if (w_push) begin
          r_mem[r_wrPtr] <= {w_gnt, w_sat[5:0]};
          r_wrPtr        <= r_wrPtr + PW'(1);
          r_last[w_gnt]  <= r_last[w_gnt] + w_sat;
          r_rrPtr        <= w_gnt + 2'd1;
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + CW'(1);
        end else if (w_pop && !w_push) begin
          r_count <= r_count - CW'(1);
        end
      end
    end
  end

  // Register read mux; reads never change state.
  always_comb begin
    o_data_out = 8'h00;
    case (i_address)
      4'h8:    o_data_out = w_empty ? 8'h00 : r_mem[r_rdPtr];
      4'hA:    o_data_out = {r_enable, w_full, w_empty, 1'b0, 4'(r_count)};
      4'hB:    o_data_out = {7'b0, r_enable};
      default: o_data_out = 8'h00;
    endcase
  end

  assign o_irq = r_enable && !w_empty;

endmodule

// File: tb/tb_tqvp_matt_encoder_event_arb.sv
// tb_tqvp_matt_encoder_event_arb
//   Directed bench for the encoder event arbiter: reset state, single and
//   saturated events, round-robin order, full-FIFO back-pressure, enable
//   and flush control, and asynchronous reset mid-stream.
module tb_tqvp_matt_encoder_event_arb;

  logic        clk;
  logic        rst_n;
  logic [31:0] encValue;
  logic [3:0]  address;
  logic        dataWrite;
  logic [7:0]  dataIn;
  logic [7:0]  dataOut;
  logic        irq;

  int checks;
  int errors;

  tqvp_matt_encoder_event_arb #(.WIDTH(8), .DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enc_value  (encValue),
    .i_address    (address),
    .i_data_write (dataWrite),
    .i_data_in    (dataIn),
    .o_data_out   (dataOut),
    .o_irq        (irq)
  );

  // Free-running clock, 20 time units per period.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle register write.
  task automatic applyStimulus(input logic [3:0] addr, input logic [7:0] data);
    address   = addr;
    dataIn    = data;
    dataWrite = 1'b1;
    tick();
    dataWrite = 1'b0;
    dataIn    = 8'h00;
  endtask

  // Read a register combinationally and compare.
  task automatic checkOutput(input logic [3:0] addr, input logic [7:0] expected, input string tag);
    address = addr;
    #1;
    checks++;
    assert (dataOut === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%02h expected 0x%02h", tag, dataOut, expected);
    end
  endtask

  task automatic checkIrq(input logic expected, input string tag);
    #1;
    checks++;
    assert (irq === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, irq, expected);
    end
  endtask

  task automatic setChannel(input int ch, input logic [7:0] value);
    encValue[ch*8 +: 8] = value;
  endtask

  // Directed sequence; each step's expected values are worked out by hand.
  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    encValue  = 32'h0;
    address   = 4'h0;
    dataWrite = 1'b0;
    dataIn    = 8'h00;
    #25;
    rst_n = 1'b1;
    tick();

    $display("[TB] reset state");
    checkOutput(4'hA, 8'hA0, "reset_status");
    checkOutput(4'h8, 8'h00, "reset_head");
    checkOutput(4'hB, 8'h01, "reset_ctrl");
    checkIrq(1'b0, "reset_irq");

    $display("[TB] single event ch2 +3");
    setChannel(2, 8'd3);
    tick();
    checkOutput(4'h8, 8'h83, "ch2_head");
    checkOutput(4'hA, 8'h81, "ch2_status");
    checkOutput(4'h0, 8'h00, "unmapped_read");
    checkIrq(1'b1, "ch2_irq");
    applyStimulus(4'h9, 8'h00);
    checkOutput(4'hA, 8'hA0, "ch2_pop_status");
    checkIrq(1'b0, "ch2_pop_irq");
    applyStimulus(4'h9, 8'h00);
    checkOutput(4'hA, 8'hA0, "pop_empty_ignored");

    $display("[TB] async reset mid-stream");
    setChannel(2, 8'd5);
    tick();
    checkOutput(4'h8, 8'h82, "ch2_second_head");
    rst_n = 1'b0;
    checkOutput(4'hA, 8'hA0, "async_reset_status");
    checkOutput(4'h8, 8'h00, "async_reset_head");
    checkIrq(1'b0, "async_reset_irq");
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput(4'h8, 8'h85, "post_reset_vs_zero");
    applyStimulus(4'h9, 8'h00);

    $display("[TB] negative delta and saturation");
    setChannel(0, 8'hFE);
    tick();
    checkOutput(4'h8, 8'h3E, "ch0_minus2");
    applyStimulus(4'h9, 8'h00);
    setChannel(1, 8'd100);
    tick();
    checkOutput(4'h8, 8'h5F, "sat_entry0");
    applyStimulus(4'h9, 8'h00);
    checkOutput(4'h8, 8'h5F, "sat_entry1");
    applyStimulus(4'h9, 8'h00);
    checkOutput(4'h8, 8'h5F, "sat_entry2");
    applyStimulus(4'h9, 8'h00);
    checkOutput(4'h8, 8'h47, "sat_remainder");
    applyStimulus(4'h9, 8'h00);
    checkOutput(4'hA, 8'hA0, "sat_drained");

    $display("[TB] round robin and full FIFO");
    applyStimulus(4'hB, 8'h03);
    setChannel(0, 8'hFF);
    setChannel(1, 8'd101);
    setChannel(2, 8'd6);
    setChannel(3, 8'd1);
    tick();
    tick();
    tick();
    tick();
    checkOutput(4'hA, 8'hC4, "rr_full_status");
    checkIrq(1'b1, "rr_full_irq");
    setChannel(0, 8'h00);
    tick();
    tick();
    checkOutput(4'hA, 8'hC4, "full_blocks_push");
    checkOutput(4'h8, 8'h01, "rr_head_ch0");
    applyStimulus(4'h9, 8'h00);
    checkOutput(4'hA, 8'h83, "pop_while_full_count3");
    checkOutput(4'h8, 8'h41, "rr_head_ch1");
    tick();
    checkOutput(4'hA, 8'hC4, "push_after_pop_count4");
    applyStimulus(4'h9, 8'h00);
    checkOutput(4'h8, 8'h81, "rr_head_ch2");
    applyStimulus(4'h9, 8'h00);
    checkOutput(4'h8, 8'hC1, "rr_head_ch3");
    applyStimulus(4'h9, 8'h00);
    checkOutput(4'h8, 8'h01, "late_ch0_wrap");
    applyStimulus(4'h9, 8'h00);
    checkOutput(4'hA, 8'hA0, "rr_drained");

    $display("[TB] enable and flush");
    applyStimulus(4'hB, 8'h00);
    checkOutput(4'hB, 8'h00, "ctrl_disabled");
    setChannel(3, 8'd6);
    tick();
    tick();
    tick();
    checkOutput(4'hA, 8'h20, "disabled_no_entry");
    checkIrq(1'b0, "disabled_irq");
    applyStimulus(4'hB, 8'h03);
    tick();
    tick();
    checkOutput(4'hA, 8'hA0, "flush_no_event");
    checkOutput(4'h8, 8'h00, "flush_head_empty");
    checkIrq(1'b0, "flush_irq");

    $display("[TB] accumulated delta on re-enable");
    applyStimulus(4'hB, 8'h00);
    setChannel(3, 8'd8);
    tick();
    checkOutput(4'hA, 8'h20, "accum_disabled");
    applyStimulus(4'hB, 8'h01);
    tick();
    checkOutput(4'h8, 8'hC2, "accum_reported");
    checkIrq(1'b1, "accum_irq");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
